// File: rtl/pcm_dac4.sv
// First-order error-feedback noise shaper: reduces a held signed PCM sample to a DAC code.
// Optional LFSR dither is enabled by defining PCM_DAC4_DITHER_EN.
module pcm_dac4 #(
    parameter int PCM_BITS = 12,
    parameter int DAC_BITS = 4,
    parameter int DIV      = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [PCM_BITS-1:0] pcm,
    output logic                       tick,
    output logic        [DAC_BITS-1:0] dac
);

    localparam int ERR_BITS = PCM_BITS - DAC_BITS;
    localparam logic [DAC_BITS-1:0] DAC_MID = {1'b1, {(DAC_BITS-1){1'b0}}};

    logic [DIV-1:0]      cnt_q;
    logic [PCM_BITS-1:0] sample_q;
    logic [ERR_BITS-1:0] err_q, err_d;
    logic [DAC_BITS-1:0] dac_q, dac_d;
    logic                tick_q;
    logic                capture;
    logic [PCM_BITS-1:0] u;
    logic [PCM_BITS:0]   dither;
    logic [PCM_BITS:0]   sum;

    assign capture = &cnt_q;
    assign u       = {~sample_q[PCM_BITS-1], sample_q[PCM_BITS-2:0]};

`ifdef PCM_DAC4_DITHER_EN
    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // Taps 16,14,13,11: maximal length, so a non-zero seed never reaches zero.
    assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign dither = (PCM_BITS+1)'(lfsr_q[2:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign dither = '0;
`endif

    always_comb begin
        sum   = {1'b0, u} + (PCM_BITS+1)'(err_q) + dither;
        dac_d = sum[PCM_BITS-1:ERR_BITS];
        err_d = sum[ERR_BITS-1:0];
        // Saturate on carry-out instead of wrapping to code 0.
        if (sum[PCM_BITS]) begin
            dac_d = '1;
            err_d = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            sample_q <= '0;
            err_q    <= '0;
            tick_q   <= 1'b0;
            dac_q    <= DAC_MID;
        end else begin
            cnt_q  <= cnt_q + 1'b1;
            tick_q <= capture;
            if (capture) begin
                sample_q <= pcm;
            end
            err_q <= err_d;
            dac_q <= dac_d;
        end
    end

    assign tick = tick_q;
    assign dac  = dac_q;

endmodule

// File: tb/tb_pcm_dac4.sv
// Directed bench for pcm_dac4: reset behaviour, capture timing, modulator sequences.
module tb_pcm_dac4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic signed [11:0] pcm = 12'sh000;
    logic              tick;
    logic        [3:0] dac;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    pcm_dac4 #(
        .PCM_BITS(12),
        .DAC_BITS(4),
        .DIV     (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .pcm (pcm),
        .tick(tick),
        .dac (dac)
    );

    // exp is written left-to-right in time order: exp[3] is the first code after tick.
    typedef struct {
        logic [11:0]     pcm;
        logic [3:0][3:0] exp;
    } vec_t;

    vec_t vecs[9];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic wait_tick(input int budget, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (tick !== 1'b1 && n < budget);
    endtask

    task automatic do_reset(input logic [11:0] p);
        rst = 1'b1;
        pcm = p;
        repeat (2) step();
        rst = 1'b0;
    endtask

`ifdef PCM_DAC4_DITHER_EN
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int bad;
`ifdef PCM_DAC4_DITHER_EN
        logic [15:0] s;
        longint      dsum;
        longint      acc;
        longint      diff;
        int          zero_hits;
        do_reset(12'h000);
        s         = 16'hACE1;
        dsum      = 0;
        acc       = 0;
        bad       = 0;
        zero_hits = 0;
        for (int k = 0; k < 4096; k++) begin
            dsum += longint'(s[2:0]);
            s = lfsr_next(s);
            step();
            acc += longint'(dac);
            if (dac != 4'd8 && dac != 4'd9) bad++;
            if (dut.lfsr_q == 16'h0000) zero_hits++;
        end
        check("dither_range", bad, 0);
        check("dither_lfsr_nonzero", zero_hits, 0);
        diff = acc * 256 - (64'd4096 * 2048 + dsum);
        check("dither_mean", (diff <= 256 && diff >= -256) ? 1 : 0, 1);
`else
        vecs[0] = '{pcm: 12'h000, exp: {4'd8,  4'd8,  4'd8,  4'd8}};
        vecs[1] = '{pcm: 12'h080, exp: {4'd8,  4'd9,  4'd8,  4'd9}};
        vecs[2] = '{pcm: 12'h7FF, exp: {4'd15, 4'd15, 4'd15, 4'd15}};
        vecs[3] = '{pcm: 12'h800, exp: {4'd0,  4'd0,  4'd0,  4'd0}};
        vecs[4] = '{pcm: 12'h100, exp: {4'd9,  4'd9,  4'd9,  4'd9}};
        vecs[5] = '{pcm: 12'h040, exp: {4'd8,  4'd8,  4'd8,  4'd9}};
        vecs[6] = '{pcm: 12'hF00, exp: {4'd7,  4'd7,  4'd7,  4'd7}};
        vecs[7] = '{pcm: 12'h7C0, exp: {4'd15, 4'd15, 4'd15, 4'd15}};
        vecs[8] = '{pcm: 12'h0C0, exp: {4'd8,  4'd9,  4'd9,  4'd9}};

        // Reset held three clocks: midscale code, no tick.
        rst = 1'b1;
        pcm = 12'h123;
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("reset_dac%0d", k), dac, 8);
            check($sformatf("reset_tick%0d", k), tick, 0);
        end
        rst = 1'b0;
        n   = 0;
        bad = 0;
        do begin
            step();
            n++;
            if (dac !== 4'd8) bad++;
        end while (tick !== 1'b1 && n < 300);
        check("first_tick_latency", n, 256);
        check("dac_mid_before_capture", bad, 0);

        foreach (vecs[i]) begin
            do_reset(vecs[i].pcm);
            wait_tick(300, n);
            check($sformatf("vec%0d_tick_latency", i), n, 256);
            check($sformatf("vec%0d_dac_at_tick", i), dac, 8);
            for (int j = 3; j >= 0; j--) begin
                step();
                check($sformatf("vec%0d_dac%0d", i, 3 - j), dac, vecs[i].exp[j]);
                if (j == 3) check($sformatf("vec%0d_tick_pulse", i), tick, 0);
            end
        end

        // Sample must hold between captures; pcm glitch just before tick is what gets captured.
        do_reset(12'h100);
        wait_tick(300, n);
        check("hold_first_tick", n, 256);
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (dac !== 4'd9 || tick !== 1'b0) bad++;
        end
        pcm = 12'h7FF;
        for (int k = 0; k < 10; k++) begin
            step();
            if (dac !== 4'd9 || tick !== 1'b0) bad++;
        end
        pcm = 12'h100;
        for (int k = 0; k < 239; k++) begin
            step();
            if (dac !== 4'd9 || tick !== 1'b0) bad++;
        end
        check("hold_ignores_pcm", bad, 0);
        step();
        check("pre_tick_dac", dac, 9);
        pcm = 12'h000;
        step();
        check("glitch_tick", tick, 1);
        check("glitch_dac_at_tick", dac, 9);
        pcm = 12'h100;
        step();
        check("glitch_dac_after1", dac, 8);
        check("glitch_tick_low", tick, 0);
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (dac !== 4'd8) bad++;
        end
        check("glitch_sample_held", bad, 0);

        // Mid-period reset discards error; 0x080 restarts its 8,9 pattern from err=0.
        do_reset(12'h080);
        wait_tick(300, n);
        repeat (3) step();
        rst = 1'b1;
        step();
        check("midreset_dac", dac, 8);
        rst = 1'b0;
        wait_tick(300, n);
        check("midreset_tick_latency", n, 256);
        step();
        check("midreset_seq0", dac, 8);
        step();
        check("midreset_seq1", dac, 9);
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
